serial_sub_ctrl: RTL and testbench

- Bit-serial subtraction controller: computes diff = a - b - bin over WIDTH bits, LSB first, on a single 1-bit full-subtractor cell.
- Accepts operands on a start strobe, sequences one bit per clock, and registers the borrow between bits.
- Presents the registered result with a one-cycle done pulse.
- Used where area matters more than latency; the upstream block owns the operands until done.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/fs_cell.sv | 21 ++
 rtl/serial_sub_ctrl.sv | 116 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fs_cell.sv
// 1-bit full subtractor: two half-subtractor stages, borrows OR-ed.
// Purely combinational; no latency, no backpressure.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  assign d1 = a ^ b;
  assign b1 = ~a & b;
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;
  assign bo = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first, one bit per clock. Optional zero flag: SERIAL_SUB_ZERO_FLAG_EN.
// Latency: done pulses WIDTH+1 cycles after start is sampled; diff/bout valid while done is high.
// No backpressure: start is ignored unless IDLE; upstream holds operands' ownership until done.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_fin;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;

  fs_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (brw),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  assign d_fin = {cell_d, d_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load from the final cell output as SHIFT exits, so they
  // already hold the answer during the DONE cycle when done is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_fin;
          brw  <= cell_bo;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            diff <= d_fin;
            bout <= cell_bo;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero <= (d_fin == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboarded bench for serial_sub_ctrl plus a standalone fs_cell check.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         zero;
`endif

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    .zero  (zero)
`endif
  );

  logic fa, fb, fbin, fd, fbo;
  fs_cell u_fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bo(fbo));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   bw = 0;
  int   ops = 0;
  int   dones = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit unsigned arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int at);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    e.diff = t[W-1:0];
    e.bout = t[W];
    e.cyc  = at;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bw = 0;
    end else begin
      if (busy) bw++;
      else if (bw != 0) begin
        chk("busy_width", bw, W);
        bw = 0;
      end
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("diff", diff, e.diff);
          chk("bout", bout, e.bout);
          chk("done_latency", cyc, e.cyc + W + 1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          chk("zero", zero, (e.diff == '0));
`endif
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 1, 0);
  endtask

  // Issue one operation; inputs are scrambled while busy to prove capture.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    bin = c;
    q.push_back(model(x, y, c, cyc));
    ops++;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
    wait_done();
  endtask

  initial begin
    int idle_busy;

    for (int i = 0; i < 8; i++) begin
      logic [1:0] t;
      {fa, fb, fbin} = 3'(i);
      #1;
      t = {1'b0, fa} - {1'b0, fb} - {1'b0, fbin};
      chk("fs_cell", {fbo, fd}, t);
    end

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    chk("rst_zero", zero, 0);
`endif
    @(negedge clk);
    #1 rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h7F, 8'h7E, 1'b1);

    // start held through busy and done must yield exactly one operation
    @(negedge clk);
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    bin = 1'b0;
    q.push_back(model(8'h10, 8'h01, 1'b0, cyc));
    ops++;
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    wait_done();
    @(negedge clk);
    start = 1'b0;
    idle_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    chk("no_restart", idle_busy, 0);

    // reset in the fourth SHIFT cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    a = 8'h55;
    b = 8'h22;
    bin = 1'b0;
    q.push_back(model(8'h55, 8'h22, 1'b0, cyc));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    void'(q.pop_back());
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    run_op(8'hA0, 8'h0F, 1'b1);

    for (int n = 0; n < 1000; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    repeat (4) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("done_count", dones, ops);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
